// File: rtl/hamming15_serial_tx_pkg.sv
// Shared definitions for the Hamming(15,11) serial transmitter and its
// future receiver/checker: frame length, FSM encodings, and the
// data-to-codeword position mapping.
// Optional feature macro: HAMMING_SECDED_EN appends an overall-parity bit
// as codeword position 16.
package hamming15_serial_tx_pkg;

  // Data and parity widths of the base Hamming(15,11) code
  localparam int DATA_LEN = 11;
  localparam int PAR_LEN  = 4;
  localparam int BASE_LEN = 15;

  // Serialised frame length: 15 positions, or 16 with the overall parity bit
`ifdef HAMMING_SECDED_EN
  localparam int CW_LEN = 16;
`else
  localparam int CW_LEN = 15;
`endif

  // Position counter covers 0..CW_LEN-1; gap counter covers 0..7
  localparam int CNT_W     = 4;
  localparam int GAP_CNT_W = 3;

  // Transmitter FSM encodings
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Codeword position (1-based) carrying d[i]; parity bits own 1, 2, 4, 8
  localparam int DATA_POS [DATA_LEN] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  // Data bits covered by each parity bit, index k -> p(2^k).
  // Bit i is set when DATA_POS[i] has bit k set:
  //   p1: d0 d1 d3 d4 d6 d8 d10  p2: d0 d2 d3 d5 d6 d9 d10
  //   p4: d1 d2 d3 d7 d8 d9 d10  p8: d4..d10
  localparam logic [DATA_LEN-1:0] PAR_MASK [PAR_LEN] = '{
    11'h55B,
    11'h66D,
    11'h78E,
    11'h7F0
  };

endpackage

// File: rtl/hamming15_parity.sv
// Combinational Hamming(15,11) encoder: computes the four even-parity bits
// and assembles the 15-bit codeword. codeword[i-1] holds position i.
// Shared with the receiver/checker, so it is independent of the
// HAMMING_SECDED_EN macro; the overall parity bit is added by the caller.
module hamming15_parity
  import hamming15_serial_tx_pkg::*;
(
  input  logic [DATA_LEN-1:0] data,
  output logic [PAR_LEN-1:0]  parity,
  output logic [BASE_LEN-1:0] codeword
);

  // Parity bits: even parity over the data bits they cover, placed at
  // power-of-two positions 1, 2, 4, 8
  for (genvar gi = 0; gi < PAR_LEN; gi++) begin : g_par
    assign parity[gi]                 = ^(data & PAR_MASK[gi]);
    assign codeword[(1 << gi) - 1]    = parity[gi];
  end

  // Data bits fill the remaining non-power-of-two positions in order
  for (genvar gi = 0; gi < DATA_LEN; gi++) begin : g_data
    assign codeword[DATA_POS[gi] - 1] = data[gi];
  end

endmodule

// File: rtl/hamming15_serial_tx.sv
// Hamming(15,11) serial transmitter: accepts an 11-bit word, encodes it and
// shifts the codeword out LSB-first (position 1 first), one bit per clock.
// parity_out holds the parity of the frame in flight until the next accept.
// Optional feature macro: HAMMING_SECDED_EN adds position 16 (overall parity)
// to each frame and exposes it on ser_overall.
module hamming15_serial_tx
  import hamming15_serial_tx_pkg::*;
#(
  parameter int DATA_W     = 11,
  parameter int PAR_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_first,
  output logic              ser_last,
  output logic [PAR_W-1:0]  parity_out,
  output logic              busy
`ifdef HAMMING_SECDED_EN
  ,
  output logic              ser_overall
`endif
);

  // The code is fixed; reject any other geometry at elaboration
  if (DATA_W != DATA_LEN) begin : g_bad_data_w
    $error("hamming15_serial_tx: DATA_W must be 11");
  end
  if (PAR_W != PAR_LEN) begin : g_bad_par_w
    $error("hamming15_serial_tx: PAR_W must be 4");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 7) begin : g_bad_gap
    $error("hamming15_serial_tx: GAP_CYCLES must be in 0..7");
  end

  localparam bit                   NO_GAP   = (GAP_CYCLES == 0);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ?
                                              GAP_CNT_W'(GAP_CYCLES - 1) :
                                              '0;
  localparam logic [CNT_W-1:0]     LAST_POS = CNT_W'(CW_LEN - 1);

  state_t               state_reg,  state_next;
  logic [CNT_W-1:0]     cnt_reg,    cnt_next;
  logic [CW_LEN-1:0]    shift_reg,  shift_next;
  logic [GAP_CNT_W-1:0] gap_reg,    gap_next;
  logic [PAR_LEN-1:0]   parity_reg, parity_next;

  logic [PAR_LEN-1:0]   parity_calc;
  logic [BASE_LEN-1:0]  codeword_calc;
  logic [CW_LEN-1:0]    frame_word;
  logic                 last_pos;
  logic                 accept;

  hamming15_parity u_parity (
    .data     (in_data),
    .parity   (parity_calc),
    .codeword (codeword_calc)
  );

`ifdef HAMMING_SECDED_EN
  logic overall_reg, overall_next;
  logic overall_calc;

  // Overall parity makes the whole 16-bit frame even
  assign overall_calc = ^codeword_calc;
  assign frame_word   = {overall_calc, codeword_calc};
  assign ser_overall  = overall_reg;
`else
  assign frame_word   = codeword_calc;
`endif

  // Handshake: the acceptance window is IDLE, plus the final position of a
  // frame when no gap follows, which gives bubble-free back-to-back frames
  assign last_pos = (state_reg == SHIFT) && (cnt_reg == LAST_POS);
  assign in_ready = (state_reg == IDLE) || (last_pos && NO_GAP);
  assign accept   = in_valid && in_ready;

  // Serial outputs decode directly from registered state; ser_out is
  // forced low outside a frame
  assign ser_valid  = (state_reg == SHIFT);
  assign ser_out    = ser_valid && shift_reg[0];
  assign ser_first  = ser_valid && (cnt_reg == '0);
  assign ser_last   = last_pos;
  assign parity_out = parity_reg;
  assign busy       = (state_reg != IDLE);

  // FSM state register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath update; an accept always (re)loads the frame
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shift_next  = shift_reg;
    gap_next    = gap_reg;
    parity_next = parity_reg;

    case (state_reg)
      IDLE: begin
        cnt_next   = '0;
        shift_next = '0;
      end
      SHIFT: begin
        if (!last_pos) begin
          shift_next = shift_reg >> 1;
          cnt_next   = cnt_reg + 1'b1;
        end else begin
          shift_next = '0;
          cnt_next   = '0;
          gap_next   = '0;
          state_next = NO_GAP ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_reg == GAP_LAST) begin
          gap_next   = '0;
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        shift_next = '0;
        gap_next   = '0;
      end
    endcase

    if (accept) begin
      state_next  = SHIFT;
      cnt_next    = '0;
      shift_next  = frame_word;
      parity_next = parity_calc;
    end
  end

  // Datapath registers: position counter, shifter, gap counter, held parity
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_reg    <= '0;
      shift_reg  <= '0;
      gap_reg    <= '0;
      parity_reg <= '0;
    end else begin
      cnt_reg    <= cnt_next;
      shift_reg  <= shift_next;
      gap_reg    <= gap_next;
      parity_reg <= parity_next;
    end
  end

`ifdef HAMMING_SECDED_EN
  // Overall parity is held alongside parity_out for the frame in flight
  always_comb begin
    overall_next = overall_reg;
    if (accept) begin
      overall_next = overall_calc;
    end
  end

  // Held overall parity register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      overall_reg <= 1'b0;
    end else begin
      overall_reg <= overall_next;
    end
  end
`endif

endmodule

// File: tb/tb_hamming15_serial_tx.sv
// Directed bench for hamming15_serial_tx. Two instances share the clock and
// reset: dut0 with GAP_CYCLES=0 and dut3 with GAP_CYCLES=3.
// Expected codewords and parities are worked out by hand.
// Honours HAMMING_SECDED_EN (16-position frames, ser_overall).
module tb_hamming15_serial_tx;

`ifdef HAMMING_SECDED_EN
  localparam int CW = 16;
`else
  localparam int CW = 15;
`endif

  logic        clock = 1'b0;
  logic        clear;
  logic [10:0] in_data0, in_data3;
  logic        in_valid0, in_valid3;
  logic        rdy0, so0, sv0, sf0, sl0, busy0;
  logic        rdy3, so3, sv3, sf3, sl3, busy3;
  logic [3:0]  par0, par3;
`ifdef HAMMING_SECDED_EN
  logic        ovr0, ovr3;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  hamming15_serial_tx #(.DATA_W(11), .PAR_W(4), .GAP_CYCLES(0)) dut0 (
    .clock      (clock),
    .clear      (clear),
    .in_data    (in_data0),
    .in_valid   (in_valid0),
    .in_ready   (rdy0),
    .ser_out    (so0),
    .ser_valid  (sv0),
    .ser_first  (sf0),
    .ser_last   (sl0),
    .parity_out (par0),
    .busy       (busy0)
`ifdef HAMMING_SECDED_EN
    ,
    .ser_overall(ovr0)
`endif
  );

  hamming15_serial_tx #(.DATA_W(11), .PAR_W(4), .GAP_CYCLES(3)) dut3 (
    .clock      (clock),
    .clear      (clear),
    .in_data    (in_data3),
    .in_valid   (in_valid3),
    .in_ready   (rdy3),
    .ser_out    (so3),
    .ser_valid  (sv3),
    .ser_first  (sf3),
    .ser_last   (sl3),
    .parity_out (par3),
    .busy       (busy3)
`ifdef HAMMING_SECDED_EN
    ,
    .ser_overall(ovr3)
`endif
  );

  // One comparison: count it, report a mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge of the position-1 cycle; walks every position and
  // returns at the negedge of the last position.
  // Per-cycle word: {ser_valid, ser_first, ser_last, ser_out, in_ready, busy}
  task automatic check_frame(input string tag, input int which, input logic [14:0] cw,
                             input logic [3:0] par, input logic ovr, input logic toggle);
    logic [15:0] word;
    logic [5:0]  obs;
    logic [5:0]  exp;
    logic [3:0]  par_obs;
    word = {ovr, cw};
    for (int p = 0; p < CW; p++) begin
      if (p > 0) @(negedge clock);
      if (toggle) in_data3 = ~in_data3;
      obs = (which == 0) ? {sv0, sf0, sl0, so0, rdy0, busy0}
                         : {sv3, sf3, sl3, so3, rdy3, busy3};
      exp = {1'b1, (p == 0), (p == CW - 1), word[p[3:0]],
             (which == 0) && (p == CW - 1), 1'b1};
      check($sformatf("%s pos%0d", tag, p + 1), {26'd0, obs}, {26'd0, exp});
      if (p == 0 || p == CW - 1) begin
        par_obs = (which == 0) ? par0 : par3;
        check($sformatf("%s parity pos%0d", tag, p + 1), {28'd0, par_obs}, {28'd0, par});
      end
    end
`ifdef HAMMING_SECDED_EN
    check($sformatf("%s overall", tag), {31'd0, (which == 0) ? ovr0 : ovr3}, {31'd0, ovr});
`endif
  endtask

  // Single isolated frame on dut0, followed by an idle check
  task automatic send0(input string tag, input logic [10:0] data, input logic [14:0] cw,
                       input logic [3:0] par, input logic ovr);
    @(negedge clock);
    in_data0  = data;
    in_valid0 = 1'b1;
    check({tag, " ready"}, {31'd0, rdy0}, 32'd1);
    @(negedge clock);
    in_valid0 = 1'b0;
    check_frame(tag, 0, cw, par, ovr, 1'b0);
    @(negedge clock);
    // {ser_valid, ser_out, busy, in_ready, parity_out}
    check({tag, " idle"}, {24'd0, sv0, so0, busy0, rdy0, par0}, {24'd0, 4'b0001, par});
  endtask

  initial begin
    clear     = 1'b0;
    in_data0  = '0;
    in_data3  = '0;
    in_valid0 = 1'b0;
    in_valid3 = 1'b0;

    // Reset state: {busy, ser_valid, ser_out, ser_first, ser_last, in_ready, parity_out}
    repeat (3) @(negedge clock);
    check("reset dut0", {22'd0, busy0, sv0, so0, sf0, sl0, rdy0, par0}, {22'd0, 6'b000001, 4'h0});
    check("reset dut3", {22'd0, busy3, sv3, so3, sf3, sl3, rdy3, par3}, {22'd0, 6'b000001, 4'h0});
    clear = 1'b1;

    // Mid-frame reset: 11'h2A5 -> codeword 15'h2AAD, parity 4'hD
    @(negedge clock);
    in_data0  = 11'h2A5;
    in_valid0 = 1'b1;
    @(negedge clock);
    in_valid0 = 1'b0;
    check("abort pos1", {26'd0, sv0, sf0, so0, busy0, par0[1:0]}, {26'd0, 4'b1111, 2'b01});
    check("abort par", {28'd0, par0}, 32'hD);
    repeat (2) @(negedge clock);
    check("abort pos3", {29'd0, sv0, so0, busy0}, {29'd0, 3'b111});
    #2 clear = 1'b0;
    #1;
    check("abort async", {22'd0, busy0, sv0, so0, sf0, sl0, rdy0, par0}, {22'd0, 6'b000001, 4'h0});
    repeat (2) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check("after release", {29'd0, rdy0, sv0, busy0}, {29'd0, 3'b100});
    repeat (3) @(negedge clock);
    check("no resume", {29'd0, rdy0, sv0, busy0}, {29'd0, 3'b100});

    // Single frames on dut0
    send0("d000", 11'h000, 15'h0000, 4'b0000, 1'b0);
    send0("d001", 11'h001, 15'h0007, 4'b0011, 1'b1);
    send0("d7ff", 11'h7FF, 15'h7FFF, 4'b1111, 1'b1);
    send0("d400", 11'h400, 15'h408B, 4'b1111, 1'b1);
    send0("d2a5", 11'h2A5, 15'h2AAD, 4'b1101, 1'b0);

    // Back-to-back on dut0: valid held high, second frame follows with no bubble
    @(negedge clock);
    in_data0  = 11'h001;
    in_valid0 = 1'b1;
    @(negedge clock);
    in_data0  = 11'h7FF;
    check_frame("b2b first", 0, 15'h0007, 4'b0011, 1'b1, 1'b0);
    @(negedge clock);
    in_valid0 = 1'b0;
    check_frame("b2b second", 0, 15'h7FFF, 4'b1111, 1'b1, 1'b0);
    @(negedge clock);
    check("b2b idle", {29'd0, sv0, busy0, rdy0}, {29'd0, 3'b001});

    // Backpressure on dut3: in_data churns during SHIFT and GAP, valid held high
    @(negedge clock);
    in_data3  = 11'h2A5;
    in_valid3 = 1'b1;
    check("bp ready", {31'd0, rdy3}, 32'd1);
    @(negedge clock);
    check_frame("bp frame", 3, 15'h2AAD, 4'b1101, 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      @(negedge clock);
      in_data3 = ~in_data3;
      // {ser_valid, ser_out, in_ready, busy, parity_out}
      check($sformatf("bp gap%0d", g), {24'd0, sv3, so3, rdy3, busy3, par3}, {24'd0, 4'b0001, 4'hD});
    end
    @(negedge clock);
    check("bp ready back", {30'd0, rdy3, busy3}, {30'd0, 2'b10});
    in_valid3 = 1'b0;
    @(negedge clock);
    check("bp idle", {29'd0, sv3, busy3, rdy3}, {29'd0, 3'b001});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
